// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: start/data/stop serial deframer with per-frame bit order.
// Samples ser_in only on bit_en strobes and presents each good word on data_out.
module serial_frame_receiver #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          CHECK_STOP = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ser_in,
  input  logic             bit_en,
  input  logic             dir,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic             valid_nxt, err_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-value logic; pulses default low every cycle
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    dir_nxt   = dir_q;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bit_en && !ser_in) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          dir_nxt   = dir;
        end
      end
      DATA: begin
        if (bit_en) begin
          // Latched direction picks which end the new bit enters
          if (dir_q) shift_nxt = {ser_in, shift_q[WIDTH-1:1]};
          else       shift_nxt = {shift_q[WIDTH-2:0], ser_in};
          cnt_nxt = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_en) begin
          state_nxt = IDLE;
          if (ser_in || !CHECK_STOP) begin
            data_nxt  = shift_q;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      shift_q    <= shift_nxt;
      cnt_q      <= cnt_nxt;
      dir_q      <= dir_nxt;
      data_out   <= data_nxt;
      data_valid <= valid_nxt;
      frame_err  <= err_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Testbench for serial_frame_receiver: frame-level reference model with random gaps,
// random words/directions and both stop-bit checking modes side by side.
module tb_serial_frame_receiver;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         ser_in;
  logic         bit_en;
  logic         dir;
  logic [W-1:0] data_a, data_b;
  logic         valid_a, valid_b, err_a, err_b, busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  // Expected last good word for each instance
  logic [W-1:0] exp_a, exp_b;

  serial_frame_receiver #(.WIDTH(W), .CHECK_STOP(1'b1)) dut_a (
    .clk(clk), .clr(clr), .ser_in(ser_in), .bit_en(bit_en), .dir(dir),
    .data_out(data_a), .data_valid(valid_a), .frame_err(err_a), .busy(busy_a)
  );

  serial_frame_receiver #(.WIDTH(W), .CHECK_STOP(1'b0)) dut_b (
    .clk(clk), .clr(clr), .ser_in(ser_in), .bit_en(bit_en), .dir(dir),
    .data_out(data_b), .data_valid(valid_b), .frame_err(err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, wait for the edge, land 1 time unit after it
  task automatic tick(input logic en, input logic s, input logic d);
    bit_en = en;
    ser_in = s;
    dir    = d;
    @(posedge clk);
    #1;
  endtask

  // Outputs expected in any cycle that is not the one after a stop strobe
  task automatic check_quiet(input string tag, input logic exp_busy);
    check({tag, " valid_a"}, 32'(valid_a), 32'd0);
    check({tag, " err_a"},   32'(err_a),   32'd0);
    check({tag, " valid_b"}, 32'(valid_b), 32'd0);
    check({tag, " err_b"},   32'(err_b),   32'd0);
    check({tag, " busy_a"},  32'(busy_a),  32'(exp_busy));
    check({tag, " busy_b"},  32'(busy_b),  32'(exp_busy));
    check({tag, " data_a"},  32'(data_a),  32'(exp_a));
    check({tag, " data_b"},  32'(data_b),  32'(exp_b));
  endtask

  task automatic gap(input int unsigned max_gap, input logic exp_busy);
    int unsigned n;
    n = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
    for (int i = 0; i < int'(n); i++) begin
      tick(1'b0, 1'($urandom), 1'($urandom));
      check_quiet("gap", exp_busy);
    end
  endtask

  // Full frame: start, W data bits in the chosen order, stop bit.
  // dir is randomised on every strobe after the start to show it is ignored.
  task automatic send_frame(input logic [W-1:0] word, input logic d,
                            input logic stop, input int unsigned max_gap);
    logic b;
    gap(max_gap, 1'b0);
    tick(1'b1, 1'b0, d);
    check_quiet("start", 1'b1);
    for (int i = 0; i < int'(W); i++) begin
      gap(max_gap, 1'b1);
      b = d ? word[i] : word[W-1-i];
      tick(1'b1, b, 1'($urandom));
      check_quiet("data", (i == int'(W) - 1) ? 1'b1 : 1'b1);
    end
    gap(max_gap, 1'b1);
    tick(1'b1, stop, 1'($urandom));
    if (stop) exp_a = word;
    exp_b = word;
    check("stop valid_a", 32'(valid_a), 32'(stop));
    check("stop err_a",   32'(err_a),   32'(!stop));
    check("stop valid_b", 32'(valid_b), 32'd1);
    check("stop err_b",   32'(err_b),   32'd0);
    check("stop data_a",  32'(data_a),  32'(exp_a));
    check("stop data_b",  32'(data_b),  32'(exp_b));
    check("stop busy_a",  32'(busy_a),  32'd0);
    check("stop busy_b",  32'(busy_b),  32'd0);
  endtask

  initial begin
    clr = 1'b1; bit_en = 1'b0; ser_in = 1'b1; dir = 1'b0;
    exp_a = '0; exp_b = '0;

    // Reset held two cycles with a toggling line
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    check_quiet("reset", 1'b0);
    clr = 1'b0;

    // Idle strobes never start a frame
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'($urandom));
      check_quiet("idle", 1'b0);
    end

    // Directed frames
    send_frame(4'b1011, 1'b0, 1'b1, 0);   // MSB first
    send_frame(4'b1111, 1'b0, 1'b0, 0);   // bad stop: a keeps 1011, b takes 1111
    send_frame(4'b1101, 1'b1, 1'b1, 1);   // LSB first: line 1,0,1,1

    // Reset mid-frame after two data bits
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    clr = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    clr = 1'b0;
    exp_a = '0; exp_b = '0;
    check_quiet("midreset", 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 0);

    // Back-to-back frames with no dead strobes
    send_frame(4'b0110, 1'b0, 1'b1, 0);
    send_frame(4'b1001, 1'b0, 1'b1, 0);

    // Random frames with idle gaps and stray idle strobes
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(3, 0) == 0) begin
        tick(1'b1, 1'b1, 1'($urandom));
        check_quiet("idle strobe", 1'b0);
      end
      send_frame(W'($urandom), 1'($urandom), ($urandom_range(3, 0) != 0), 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Serial-to-parallel receiver for the far end of the 4-bit universal shift register's serial output.
- Detects a start bit on a single-bit line, shifts in WIDTH data bits under a sample strobe, checks the stop bit, then presents the assembled word on a parallel bus.
- Bit order is selectable per frame so the block matches either shift direction of the transmitting register.

Parameters:
- WIDTH, 4, number of data bits per frame (2..16).
- CHECK_STOP, 1, when 1 a low stop bit flags frame_err and discards the word; when 0 the stop bit is sampled but ignored.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset.
- ser_in  input  1  serial line; idle level 1.
- bit_en  input  1  sample strobe; ser_in is only looked at in cycles with bit_en=1.
- dir  input  1  bit order: 0 = MSB first, 1 = LSB first. Sampled with the start bit.
- data_out  output  WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset:
  - clr=1 at a rising edge forces state=IDLE, bit counter=0 and shift register=0.
  - It also clears data_out, data_valid, frame_err and busy to 0 and the latched direction to 0.
  - clr has priority over every other input, including mid-frame. An aborted frame produces no data_valid and no frame_err.
- All outputs are registered. Nothing changes in cycles with bit_en=0 except the pulse outputs, which drop back to 0.
- State machine (states IDLE, DATA, STOP):
  - IDLE: on bit_en=1 with ser_in=0 (start bit), go to DATA, clear the counter to 0 and latch dir. A strobe with ser_in=1 stays in IDLE.
  - DATA: on each bit_en=1, shift ser_in into the register and increment the counter. On the strobe where counter==WIDTH-1, go to STOP.
    - dir=0: the register shifts left and the new bit enters bit 0, so the first bit ends in bit WIDTH-1.
    - dir=1: the register shifts right and the new bit enters bit WIDTH-1, so the first bit ends in bit 0.
  - STOP, on bit_en=1 (always returns to IDLE):
    - ser_in=1, or CHECK_STOP=0: data_out <= shift register and data_valid=1 for exactly the next cycle.
    - ser_in=0 with CHECK_STOP=1: frame_err=1 for one cycle and data_out holds its previous value.
- data_valid and frame_err are never high in the same cycle.
- Latency: both pulses appear in the cycle after the clock edge that sampled the stop bit.
- busy goes high the cycle after the start strobe. It goes low the cycle after the stop strobe, coincident with the pulse.
- Back-to-back frames: the earliest next start bit is the bit_en following the stop strobe. No dead strobes are required.
- A dir change mid-frame has no effect; the latched value applies until the frame returns to IDLE.
- The counter is clog2(WIDTH)+1 bits wide and never wraps within a frame. It is cleared on each start.
- Leaving IDLE does not clear the shift register contents. Only full frames reach data_out.

Test Plan:
- Reset: hold clr for 2 cycles with ser_in toggling -> data_out=0000, data_valid=0, frame_err=0, busy=0.
- MSB first, WIDTH=4, dir=0: strobe the line sequence 0 (start), 1, 0, 1, 1, then 1 (stop) -> one data_valid pulse, data_out=1011, busy low in the same cycle.
- LSB first, dir=1: strobe 0, 1, 0, 1, 1, 1 -> data_out=1101. Toggling dir mid-frame changes nothing.
- Framing error: strobe 0, 1, 1, 1, 1, then 0 (stop) -> frame_err pulses once, data_valid stays 0, data_out keeps its prior value 1011.
  - With CHECK_STOP=0 the same stimulus gives data_valid with data_out=1111.
- Reset mid-frame: assert clr after 2 data bits, then send the full frame 0, 0, 1, 1, 0, 1 -> a single data_valid with data_out=0110.
- Gaps and back-to-back: insert 0-3 idle cycles between strobes, then send two frames with no gap (0110 then 1001) -> two pulses with the correct words. An idle line (ser_in=1) produces no spurious start.
